// File: rtl/trace_fifo.sv
// trace_fifo: show-ahead FIFO that captures trace elements from an upstream stage tracker.
// Optional macro TRACE_FIFO_WATERMARK_EN adds high_watermark (peak occupancy since reset).
package trace_fifo_pkg;
  typedef struct packed {
    logic [1:0]  stage;  // 0 = IF, 1 = ID, 2 = EX
    logic [7:0]  tag;
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_output;
endpackage

module trace_fifo
  import trace_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ready_signal,
  input  trace_output             trace_element_in,
  input  logic                    data_request,
  output logic                    data_present,
  output trace_output             trace_element_out,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    overflow_count
`ifdef TRACE_FIFO_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0]  high_watermark
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  trace_output            mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic                   present_q, present_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   push, pop, drop;

  // A pop frees a slot in the same cycle, so a push against a full FIFO is accepted.
  assign pop  = data_request && present_q;
  assign push = ready_signal && (!full_q || pop);
  assign drop = ready_signal && full_q && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    present_d = (occ_d != '0);
    full_d    = (occ_d == OW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      present_q <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      present_q <= present_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= trace_element_in;
  end

`ifdef TRACE_FIFO_WATERMARK_EN
  logic [OW-1:0] wm_q, wm_d;

  always_comb begin
    wm_d = wm_q;
    if (occ_q > wm_q) wm_d = occ_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wm_q <= '0;
    else     wm_q <= wm_d;
  end

  assign high_watermark = wm_q;
`endif

  assign data_present      = present_q;
  assign trace_element_out = present_q ? mem[rd_ptr_q] : '0;
  assign full              = full_q;
  assign occupancy         = occ_q;
  assign overflow          = ovf_q;
  assign overflow_count    = cnt_q;

endmodule

// File: tb/tb_trace_fifo.sv
// Self-checking bench for trace_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_trace_fifo;
  import trace_fifo_pkg::*;

  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready_signal = 1'b0;
  logic        data_request = 1'b0;
  trace_output trace_element_in = '0;
  trace_output trace_element_out;
  logic        data_present, full, overflow;
  logic [3:0]  occupancy;
  logic [15:0] overflow_count;
`ifdef TRACE_FIFO_WATERMARK_EN
  logic [3:0]  high_watermark;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  trace_output mq[$];
  bit          m_ovf;
  int          m_cnt;

  trace_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .ready_signal      (ready_signal),
    .trace_element_in  (trace_element_in),
    .data_request      (data_request),
    .data_present      (data_present),
    .trace_element_out (trace_element_out),
    .full              (full),
    .occupancy         (occupancy),
    .overflow          (overflow),
    .overflow_count    (overflow_count)
`ifdef TRACE_FIFO_WATERMARK_EN
    ,
    .high_watermark    (high_watermark)
`endif
  );

  always #5 clk = ~clk;

  function automatic trace_output mk(input logic [7:0] tag);
    trace_output e;
    e.stage = 2'($urandom_range(0, 2));
    e.tag   = tag;
    e.pc    = $urandom;
    e.instr = $urandom;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ready_signal = 1'b0; data_request = 1'b0; trace_element_in = '0;
    #2;
    rst = 1'b0;
    mq.delete(); m_ovf = 0; m_cnt = 0;
  endtask

  // One clock: drive strobes, advance the model with the FIFO rules, sample 1 ns after the edge.
  task automatic step(input bit rdy, input trace_output d, input bit req);
    ready_signal = rdy; trace_element_in = d; data_request = req;
    @(posedge clk);
    if (req && mq.size() > 0) void'(mq.pop_front());
    if (rdy) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        m_ovf = 1;
        if (m_cnt < (1 << CNT_WIDTH) - 1) m_cnt++;
      end
    end
    #1;
    ready_signal = 1'b0; data_request = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (data_present !== 1'b0) begin n_fail++; $display("FAIL reset_present got %0b expected 0", data_present); end
    n_checks++; if (trace_element_out !== '0) begin n_fail++; $display("FAIL reset_out got %h expected 0", trace_element_out); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b expected 0", full); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d expected 0", occupancy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b expected 0", overflow); end
    n_checks++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d expected 0", overflow_count); end
  endtask

  task automatic test_single();
    trace_output a;
    do_reset();
    a = mk(8'h11);
    step(1, a, 0);
    n_checks++; if (data_present !== 1'b1) begin n_fail++; $display("FAIL single_present_c1 got %0b expected 1", data_present); end
    n_checks++; if (trace_element_out !== a) begin n_fail++; $display("FAIL single_out_c1 got %h expected %h", trace_element_out, a); end
    step(0, '0, 0);
    n_checks++; if (data_present !== 1'b1) begin n_fail++; $display("FAIL single_present_c2 got %0b expected 1", data_present); end
    n_checks++; if (trace_element_out !== a) begin n_fail++; $display("FAIL single_out_c2 got %h expected %h", trace_element_out, a); end
    step(0, '0, 1);
    n_checks++; if (data_present !== 1'b0) begin n_fail++; $display("FAIL single_present_c3 got %0b expected 0", data_present); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL single_occ_c3 got %0d expected 0", occupancy); end
  endtask

  task automatic test_order_wrap();
    int next_tag, exp_tag, cyc;
    bit rdy, req;
    trace_output d;
    do_reset();
    next_tag = 1; exp_tag = 1; cyc = 0;
    while (exp_tag <= 20 && cyc < 300) begin
      rdy = (next_tag <= 20) && (mq.size() < 5) && ($urandom_range(0, 3) != 0);
      req = ($urandom_range(0, 1) == 1);
      n_checks++;
      if (occupancy !== 4'(mq.size())) begin n_fail++; $display("FAIL wrap_occ got %0d expected %0d", occupancy, mq.size()); end
      if (req && mq.size() > 0) begin
        n_checks++;
        if (trace_element_out.tag !== 8'(exp_tag)) begin
          n_fail++; $display("FAIL wrap_order got tag %0d expected %0d", trace_element_out.tag, exp_tag);
        end
        exp_tag++;
      end
      d = mk(8'(next_tag));
      if (rdy) next_tag++;
      step(rdy, d, req);
      cyc++;
    end
    n_checks++;
    if (exp_tag != 21) begin n_fail++; $display("FAIL wrap_timeout got %0d pops expected 20", exp_tag - 1); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, mk(8'(i)), 0);
      if (i == 8) begin
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_at8 got %0b expected 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b expected 0", overflow); end
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b expected 1", overflow); end
    n_checks++; if (overflow_count !== 16'd2) begin n_fail++; $display("FAIL ovf_count got %0d expected 2", overflow_count); end
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL ovf_occ got %0d expected 8", occupancy); end
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (data_present !== 1'b1 || trace_element_out.tag !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_pop got present %0b tag %0d expected 1 tag %0d", data_present, trace_element_out.tag, i);
      end
      step(0, '0, 1);
    end
    n_checks++; if (data_present !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %0b expected 0", data_present); end
    // Sticky flag and counter must clear asynchronously on a mid-cycle reset.
    #2; rst = 1'b1; #1;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_async_rst got %0b expected 0", overflow); end
    n_checks++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL cnt_async_rst got %0d expected 0", overflow_count); end
    rst = 1'b0; mq.delete(); m_ovf = 0; m_cnt = 0;
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, mk(8'(i)), 0);
    step(1, mk(8'd9), 1);
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL simul_occ got %0d expected 8", occupancy); end
    n_checks++; if (overflow_count !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL simul_drop got cnt %0d ovf %0b expected 0 0", overflow_count, overflow); end
    for (int i = 2; i <= 9; i++) begin
      n_checks++;
      if (trace_element_out.tag !== 8'(i)) begin n_fail++; $display("FAIL simul_order got tag %0d expected %0d", trace_element_out.tag, i); end
      step(0, '0, 1);
    end
    n_checks++; if (data_present !== 1'b0) begin n_fail++; $display("FAIL simul_drained got %0b expected 0", data_present); end
  endtask

  task automatic test_empty_req_reset();
    do_reset();
    step(0, '0, 1);
    n_checks++;
    if (occupancy !== 4'd0 || data_present !== 1'b0 || trace_element_out !== '0) begin
      n_fail++; $display("FAIL empty_req got occ %0d present %0b expected 0 0", occupancy, data_present);
    end
    for (int i = 1; i <= 3; i++) step(1, mk(8'(i)), 0);
    n_checks++; if (occupancy !== 4'd3) begin n_fail++; $display("FAIL fill3_occ got %0d expected 3", occupancy); end
    #2; rst = 1'b1; #1;
    n_checks++; if (data_present !== 1'b0) begin n_fail++; $display("FAIL async_rst_present got %0b expected 0", data_present); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL async_rst_occ got %0d expected 0", occupancy); end
    n_checks++; if (trace_element_out !== '0) begin n_fail++; $display("FAIL async_rst_out got %h expected 0", trace_element_out); end
    rst = 1'b0; mq.delete(); m_ovf = 0; m_cnt = 0;
  endtask

  task automatic test_random();
    trace_output exp_out;
    bit rdy, req;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      exp_out = (mq.size() > 0) ? mq[0] : '0;
      n_checks++; if (data_present !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_present c%0d got %0b expected %0b", c, data_present, mq.size() > 0); end
      n_checks++; if (trace_element_out !== exp_out) begin n_fail++; $display("FAIL rnd_out c%0d got %h expected %h", c, trace_element_out, exp_out); end
      n_checks++; if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full c%0d got %0b expected %0b", c, full, mq.size() == DEPTH); end
      n_checks++; if (occupancy !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_occ c%0d got %0d expected %0d", c, occupancy, mq.size()); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d got %0b expected %0b", c, overflow, m_ovf); end
      n_checks++; if (overflow_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d expected %0d", c, overflow_count, m_cnt); end
      rdy = ($urandom_range(0, 99) < ((c < 200) ? 70 : 35));
      req = ($urandom_range(0, 99) < ((c < 200) ? 40 : 75));
      step(rdy, mk(8'($urandom)), req);
    end
  endtask

`ifdef TRACE_FIFO_WATERMARK_EN
  task automatic test_watermark();
    do_reset();
    for (int i = 0; i < 6; i++) step(1, mk(8'(i)), 0);
    for (int i = 0; i < 6; i++) step(0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, mk(8'(i)), 0);
    step(0, '0, 0);
    n_checks++; if (high_watermark !== 4'd6) begin n_fail++; $display("FAIL watermark got %0d expected 6", high_watermark); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_order_wrap();
    test_overflow();
    test_full_simul();
    test_empty_req_reset();
    test_random();
`ifdef TRACE_FIFO_WATERMARK_EN
    test_watermark();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_fifo.md
# trace_fifo

Receiving end of the tracker-to-tracker trace handoff. An upstream pipeline-stage tracker (IF, ID or EX) presents a complete `trace_output` element with a one-cycle `ready_signal` pulse. This block captures it into a show-ahead FIFO and offers it to the downstream tracker through a `data_present` / `data_request` pop interface. One instance sits at the input of every downstream tracker, decoupling stage trackers whose per-element latencies differ.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, minimum 2.
- `CNT_WIDTH`, 16, width of `overflow_count`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ready_signal` in 1: write strobe from upstream. One element is offered per cycle in which it is high.
- `trace_element_in` in `$bits(trace_output)`: element written when `ready_signal` is high.
- `data_request` in 1: pop strobe from downstream. Consumes the head element at the end of the cycle.
- `data_present` out 1: FIFO non-empty; registered.
- `trace_element_out` out `$bits(trace_output)`: head element, valid whenever `data_present` is high.
- `full` out 1: occupancy == `DEPTH`; registered.
- `occupancy` out `$clog2(DEPTH)+1`: current entry count; registered.
- `overflow` out 1: sticky flag, set on the first dropped element.
- `overflow_count` out `CNT_WIDTH`: number of dropped elements, saturating.

## Operation
- Storage is `DEPTH` entries of `trace_output`, with a write pointer and a read pointer of `$clog2(DEPTH)` bits each. Both pointers wrap modulo `DEPTH`. A separate occupancy counter disambiguates full from empty.
- Push occurs when `ready_signal && (!full || pop)`: write `trace_element_in` at `wr_ptr`, then `wr_ptr+1`.
- Pop occurs when `data_request && data_present`: `rd_ptr+1`. A `data_request` while empty is ignored and has no side effect.
- Occupancy next value: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Drop occurs when `ready_signal && full && !pop`. The element is discarded, storage and pointers are unchanged, `overflow` is set to 1, and `overflow_count` increments, saturating at all-ones.
- `trace_element_out` is `mem[rd_ptr]` when `data_present` is high, and all zeros when it is low.
- Simultaneous push and pop while empty: the push is accepted and the pop is ignored, giving occupancy 1.
- Simultaneous push and pop while full: both are accepted. Occupancy stays at `DEPTH` and no drop is recorded.
- Element ordering is strictly FIFO. No element is duplicated or reordered across pointer wrap.

## Timing
- Reset values: `data_present`=0, `full`=0, `occupancy`=0, `overflow`=0, `overflow_count`=0, `trace_element_out`=0, pointers=0. Memory contents are not reset.
- Reset asserted mid-operation flushes all entries immediately and asynchronously. Strobes coincident with reset are ignored.
- Write-to-present latency is 1 cycle: a push in cycle N gives `data_present`=1 and a valid `trace_element_out` in cycle N+1.
- Pop-to-next-head latency is 0: after a pop in cycle N, cycle N+1 presents the next element, or `data_present`=0 if the FIFO is now empty.
- Sustained throughput is one push and one pop per cycle.
- The downstream tracker may sample `trace_element_out` in the same cycle it asserts `data_request`.
- `full`, `occupancy` and `overflow` update in the cycle after the causing event.

## Configuration
- Macro: `TRACE_FIFO_WATERMARK_EN`.
- Defined: adds output port `high_watermark` of width `$clog2(DEPTH)+1`. It is a register holding the maximum `occupancy` reached since reset, updated one cycle after `occupancy`, and resets to 0.
- Undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- Single element: push element A (tag 0x11) in cycle 0, then assert `data_request` in cycle 2. Expect `data_present`=1 in cycles 1–2 with `trace_element_out`=A, then `data_present`=0 and `occupancy`=0 in cycle 3.
- Ordering and wrap: with `DEPTH`=8, push tags 1–20 interleaved with pops, keeping occupancy ≤ 5. Expect pop order exactly 1..20 with no gaps.
- Overflow: push 10 elements with no pops. Expect `full`=1 after the 8th push, `overflow`=1, `overflow_count`=2, and pops return tags 1–8 only.
- Simultaneous at full: with the FIFO full, push and pop in the same cycle. Expect `occupancy`=8, `overflow_count` unchanged, and the new tag emitted last.
- Empty request plus reset: assert `data_request` while empty, with no state change; fill 3 entries, then pulse `rst` mid-cycle. Expect all outputs to return to 0 asynchronously.
- Watermark, only when `TRACE_FIFO_WATERMARK_EN` is defined: fill to 6, drain to 0, then fill to 3. Expect `high_watermark`=6.
